// File: rtl/midi_pkg.sv
// Shared MIDI real-time constants, transport state type and tempo clamp helper.
package midi_pkg;

    localparam logic [7:0] MIDI_CLOCK = 8'hF8;
    localparam logic [7:0] MIDI_START = 8'hFA;
    localparam logic [7:0] MIDI_CONT  = 8'hFB;
    localparam logic [7:0] MIDI_STOP  = 8'hFC;
    localparam int         MIDI_PPQN  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_START,
        ST_SEND_CONT,
        ST_RUN,
        ST_SEND_STOP
    } transport_t;

    function automatic logic [8:0] bpm_clamp(input logic [8:0] v, input int unsigned lo,
                                             input int unsigned hi);
        if (32'(v) < lo) return 9'(lo);
        if (32'(v) > hi) return 9'(hi);
        return v;
    endfunction

endpackage

// File: rtl/frac_divider.sv
// Phase-accumulator divider: adds inc each enabled cycle and emits a registered
// one-cycle tick whenever the sum crosses LIMIT, keeping the remainder.
module frac_divider #(
    parameter int               WIDTH = 33,
    parameter logic [WIDTH-1:0] LIMIT = WIDTH'(1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] inc,
    output logic             tick
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sum;

    // acc stays below LIMIT and inc is far smaller, so the sum cannot overflow WIDTH
    assign sum = acc_reg + inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            tick    <= 1'b0;
        end else if (clr) begin
            acc_reg <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            if (sum >= LIMIT) begin
                acc_reg <= sum - LIMIT;
                tick    <= 1'b1;
            end else begin
                acc_reg <= sum;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/midi_clock_gen.sv
// MIDI tempo controller: 24 PPQN timing clock from a loadable BPM plus the
// Start/Stop/Continue transport, all presented on one valid/ready byte port.
module midi_clock_gen
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BPM_MIN = 30,
    parameter int unsigned BPM_MAX = 300,
    parameter int unsigned BPM_RST = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] bpm_in,
    input  logic       bpm_load,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    output logic       msg_valid,
    output logic [7:0] msg_byte,
    input  logic       msg_ready,
    output logic       running,
    output logic       beat,
    output logic       overrun
);

    localparam logic [32:0] LIMIT = 33'(64'(CLK_HZ) * 64'd60);

    transport_t  state_reg;
    logic [8:0]  bpm_reg;
    logic [1:0]  pending_reg;
    logic [1:0]  pending_next;
    logic [4:0]  beat_cnt_reg;
    logic [32:0] inc;
    logic [7:0]  cmd_byte;
    logic        tick, xfer, f8_xfer, cmd_xfer, free, is_send, tick_accept;

    assign inc      = 33'(bpm_reg) * 33'(MIDI_PPQN);
    assign xfer     = msg_valid && msg_ready;
    assign f8_xfer  = xfer && (msg_byte == MIDI_CLOCK);
    assign free     = !msg_valid || xfer;
    assign is_send  = (state_reg == ST_SEND_START) || (state_reg == ST_SEND_CONT) ||
                      (state_reg == ST_SEND_STOP);
    // An in-flight 0xF8 may still be presented in a SEND state; only the command itself counts
    assign cmd_xfer = is_send && xfer && (msg_byte == cmd_byte);
    assign tick_accept = tick && (state_reg == ST_RUN) && (pending_reg != 2'd3 || f8_xfer);

    always_comb begin
        cmd_byte = MIDI_STOP;
        case (state_reg)
            ST_SEND_START: cmd_byte = MIDI_START;
            ST_SEND_CONT:  cmd_byte = MIDI_CONT;
            default:       cmd_byte = MIDI_STOP;
        endcase
    end

    // pending counts the presented 0xF8 too; 2-bit wrap makes 3+1-1 come out as 3
    always_comb begin
        pending_next = pending_reg;
        if (tick_accept) pending_next = pending_next + 2'd1;
        if (f8_xfer)     pending_next = pending_next - 2'd1;
    end

    frac_divider #(
        .WIDTH(33),
        .LIMIT(LIMIT)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == ST_RUN),
        .clr (cmd_xfer && (state_reg != ST_SEND_STOP)),
        .inc (inc),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bpm_reg      <= 9'(BPM_RST);
            pending_reg  <= 2'd0;
            beat_cnt_reg <= 5'd0;
            msg_valid    <= 1'b0;
            msg_byte     <= 8'h00;
            running      <= 1'b0;
            beat         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            beat    <= 1'b0;
            overrun <= tick && (state_reg == ST_RUN) && (pending_reg == 2'd3) && !f8_xfer;
            if (bpm_load) bpm_reg <= bpm_clamp(bpm_in, BPM_MIN, BPM_MAX);
            if (f8_xfer) begin
                if (beat_cnt_reg == 5'(MIDI_PPQN - 1)) begin
                    beat_cnt_reg <= 5'd0;
                    beat         <= 1'b1;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 5'd1;
                end
            end
            if (free) msg_valid <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    pending_reg <= 2'd0;
                    if (!stop && start)     state_reg <= ST_SEND_START;
                    else if (!stop && cont) state_reg <= ST_SEND_CONT;
                end
                ST_SEND_START, ST_SEND_CONT, ST_SEND_STOP: begin
                    pending_reg <= 2'd0;
                    if (cmd_xfer) begin
                        if (state_reg == ST_SEND_STOP) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_RUN;
                            running   <= 1'b1;
                        end
                        if (state_reg == ST_SEND_START) beat_cnt_reg <= 5'd0;
                    end else if (free) begin
                        msg_valid <= 1'b1;
                        msg_byte  <= cmd_byte;
                    end
                end
                ST_RUN: begin
                    pending_reg <= pending_next;
                    if (stop) begin
                        state_reg <= ST_SEND_STOP;
                        running   <= 1'b0;
                    end else if (free && pending_next != 2'd0) begin
                        msg_valid <= 1'b1;
                        msg_byte  <= MIDI_CLOCK;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_clock_gen.sv
// Scoreboard bench for midi_clock_gen: expected bytes, transfer offsets and beat
// flags are queued as stimulus is driven and checked as bytes leave the DUT.
module tb_midi_clock_gen;

    localparam longint LIMIT = 60000;  // CLK_HZ = 1000

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] bpm_in = 9'd0;
    logic       bpm_load = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic       msg_ready = 1'b1;
    logic       msg_valid, running, beat, overrun;
    logic [7:0] msg_byte;

    midi_clock_gen #(
        .CLK_HZ(1000), .BPM_MIN(30), .BPM_MAX(300), .BPM_RST(120)
    ) dut (
        .clk(clk), .rst(rst), .bpm_in(bpm_in), .bpm_load(bpm_load),
        .start(start), .stop(stop), .cont(cont),
        .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_ready(msg_ready),
        .running(running), .beat(beat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         off;   // cycles after the last Start/Continue transfer, -1 = untimed
        logic       bt;    // beat expected right after this 0xF8
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         vectors = 0, miscompares = 0;
    int         cyc = 0, anchor = 0, beat_model = 0;
    int         ovr_cnt = 0, stall_bad = 0;
    logic       beat_chk = 1'b0, beat_due = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (beat_chk) begin
            check("beat", 64'(beat), 64'(beat_due));
            beat_chk = 1'b0;
        end
        if (overrun === 1'b1) ovr_cnt++;
        if (msg_valid === 1'b1 && msg_ready === 1'b0) begin
            if (prev_stall && msg_byte !== prev_byte) stall_bad++;
            prev_stall = 1'b1;
            prev_byte  = msg_byte;
        end else begin
            prev_stall = 1'b0;
        end
        if (msg_valid === 1'b1 && msg_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("queue_depth", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("byte", 64'(msg_byte), 64'(e.b));
                $display("xfer cyc=%0d byte=%02h", cyc, msg_byte);
                if (e.b == 8'hFA || e.b == 8'hFB) anchor = cyc;
                if (e.off >= 0) check("f8_time", 64'(cyc - anchor), 64'(e.off));
                if (e.b == 8'hF8) begin
                    beat_chk = 1'b1;
                    beat_due = e.bt;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, input int off);
        exp_t x;
        x.b = b; x.off = off; x.bt = 1'b0;
        if (b == 8'hF8) begin
            beat_model++;
            if (beat_model == 24) begin
                x.bt = 1'b1;
                beat_model = 0;
            end
        end
        sb.push_back(x);
    endtask

    // jth tick: first cycle k with k*inc >= j*LIMIT, plus load and transfer cycles
    task automatic expect_f8s(input int n, input int bpm);
        longint inc = longint'(bpm) * 24;
        for (int j = 1; j <= n; j++) push(8'hF8, int'((j * LIMIT + inc - 1) / inc + 2));
    endtask

    task automatic strobe(input int which);
        @(posedge clk); #1;
        case (which)
            0: begin start = 1'b1; push(8'hFA, -1); beat_model = 0; end
            1: begin cont = 1'b1;  push(8'hFB, -1); end
            default: begin stop = 1'b1; push(8'hFC, -1); end
        endcase
        @(posedge clk); #1;
        start = 1'b0; cont = 1'b0; stop = 1'b0;
    endtask

    task automatic load_bpm(input logic [8:0] v);
        @(posedge clk); #1;
        bpm_in = v; bpm_load = 1'b1;
        @(posedge clk); #1;
        bpm_load = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (sb.size() != 0 && k < budget);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(msg_valid), 64'd0);
        check("rst_byte", 64'(msg_byte), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_beat", 64'(beat), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;

        // Default tempo 120 after reset
        strobe(0); expect_f8s(2, 120); drain("drain_120", 500);
        strobe(2); drain("drain_stop120", 50);

        // Start and stop together in IDLE: stop wins, nothing sent
        @(posedge clk); #1; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1; start = 1'b0; stop = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_ss_valid", 64'(msg_valid), 64'd0);
        check("idle_ss_running", 64'(running), 64'd0);

        // 125 BPM: 0xF8 every 20 cycles, beat after 24th, stop after 30
        load_bpm(9'd125);
        strobe(0); expect_f8s(30, 125); drain("drain_125", 2000);
        check("running_run", 64'(running), 64'd1);
        strobe(2); drain("drain_stop125", 50);
        check("running_stop", 64'(running), 64'd0);

        // Continue keeps beat phase: beat after 18 more
        strobe(1); expect_f8s(18, 125); drain("drain_cont", 1000);
        strobe(2); drain("drain_stop_cont", 50);

        // Fresh start: beat after a full 24
        strobe(0); expect_f8s(24, 125); drain("drain_restart", 1000);

        // Stall 110 cycles: 5 ticks, 3 held, 2 dropped, presented byte stable
        msg_ready = 1'b0; ovr_cnt = 0; stall_bad = 0;
        repeat (110) @(posedge clk);
        #1;
        check("stall_valid", 64'(msg_valid), 64'd1);
        check("stall_byte", 64'(msg_byte), 64'hF8);
        check("stall_overrun", 64'(ovr_cnt), 64'd2);
        check("stall_stable", 64'(stall_bad), 64'd0);
        push(8'hF8, -1); push(8'hF8, -1); push(8'hF8, -1);
        msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("burst_3", 64'(sb.size()), 64'd0);

        // Second stall, then stop+start together in RUN: in-flight 0xF8, then 0xFC, rest flushed
        msg_ready = 1'b0; ovr_cnt = 0;
        repeat (55) @(posedge clk);
        #1;
        check("stall2_overrun", 64'(ovr_cnt), 64'd0);
        push(8'hF8, -1); push(8'hFC, -1);
        stop = 1'b1; start = 1'b1; msg_ready = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        drain("drain_flush", 50);
        repeat (10) @(posedge clk);
        #1;
        check("flush_running", 64'(running), 64'd0);
        check("flush_valid", 64'(msg_valid), 64'd0);

        // Clamp high: 400 -> 300, 25 ticks at 8.33-cycle average
        load_bpm(9'd400);
        strobe(0); expect_f8s(25, 300); drain("drain_300", 500);
        strobe(2); drain("drain_stop300", 50);

        // Clamp low: 5 -> 30
        load_bpm(9'd5);
        strobe(0); expect_f8s(3, 30); drain("drain_30", 1000);
        strobe(2); drain("drain_stop30", 50);

        // Async reset while a byte is stalled
        msg_ready = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", 64'(msg_valid), 64'd1);
        check("pre_rst_byte", 64'(msg_byte), 64'hFA);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(msg_valid), 64'd0);
        check("async_rst_running", 64'(running), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(msg_valid), 64'd0);
        strobe(0); expect_f8s(2, 120); drain("drain_post_rst", 500);
        strobe(2); drain("drain_stop_final", 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
